// File: rtl/fetch_unit_if.sv
// Fetch front-end bundle: instruction-memory request/response, core-side
// instruction handshake, branch redirect and queue occupancy.
interface fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  queue_count;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, queue_count,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

  // Memory/core environment side.
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, queue_count,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding word request to instruction
// memory, a small circular prefetch queue toward the core, and branch
// redirect with queue flush and discard of an in-flight response.
module fetch_unit #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [ADDR_W-1:0] drain_addr, drain_addr_nxt;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              req;
  logic              push;
  logic              pop;
  logic              has_room;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  assign redirect_tgt = bus.redirect_pc & ~(ADDR_W'(3));
  // Space is judged on the current count; a same-cycle pop only helps the next issue.
  assign has_room     = (count < CNT_W'(DEPTH));
  // A redirect flushes the queue, so any pop in that cycle is meaningless.
  assign pop          = (count != '0) && bus.instr_ready && !bus.redirect;

  // Next-state, request and push decisions for the fetch FSM.
  always_comb begin
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    drain_addr_nxt = drain_addr;
    req            = 1'b0;
    req_addr       = fetch_pc;
    push           = 1'b0;
    case (state)
      IDLE: begin
        if (bus.redirect) begin
          fetch_pc_nxt = redirect_tgt;
        end else if (has_room) begin
          req = 1'b1;
          if (bus.imem_ack) begin
            push         = 1'b1;
            fetch_pc_nxt = fetch_pc + ADDR_W'(4);
          end else begin
            state_nxt = WAIT;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        req = 1'b1;
        if (bus.redirect) begin
          fetch_pc_nxt = redirect_tgt;
          if (bus.imem_ack) begin
            state_nxt = IDLE;
          end else begin
            // Remember the abandoned address so the request stays stable.
            drain_addr_nxt = fetch_pc;
            state_nxt      = DRAIN;
          end
        end else if (bus.imem_ack) begin
          push         = 1'b1;
          fetch_pc_nxt = fetch_pc + ADDR_W'(4);
          state_nxt    = IDLE;
        end else begin
          state_nxt = WAIT;
        end
      end
      DRAIN: begin
        req      = 1'b1;
        req_addr = drain_addr;
        if (bus.redirect) begin
          fetch_pc_nxt = redirect_tgt;
          state_nxt    = DRAIN;
        end else if (bus.imem_ack) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DRAIN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state, fetch PC and held drain address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      drain_addr <= '0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      drain_addr <= drain_addr_nxt;
    end
  end

  // Queue pointers and occupancy; redirect flushes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue payload storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= bus.imem_rdata;
      pc_mem[wr_ptr]   <= fetch_pc;
    end
  end

  // Reset forces the request low immediately, abandoning any transaction.
  assign bus.imem_req    = req && !rst;
  assign bus.imem_addr   = bus.imem_req ? req_addr : '0;
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = bus.instr_valid ? data_mem[rd_ptr] : '0;
  assign bus.instr_pc    = bus.instr_valid ? pc_mem[rd_ptr] : '0;
  assign bus.queue_count = count;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run. Expected instruction stream is a contiguous word sequence starting at
// the last reset/redirect target, with data given by the memory contents.
module tb_fetch_unit;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) bus ();

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;
  int mem_lat  = 0;
  int wcnt     = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h8) return 32'hE3A01005;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Memory model: acks after mem_lat waiting cycles, drops state on reset.
  always_comb begin
    bus.imem_ack   = bus.imem_req && (wcnt >= mem_lat);
    bus.imem_rdata = memf(bus.imem_addr);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic seed(input logic [31:0] s);
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < 1000; i++) begin
      e.pc  = s + 32'(i * 4);
      e.ins = memf(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    cyc();
    rst = 1'b1;
    bus.redirect = 1'b0;
    mem_lat = 0;
    bus.instr_ready = rdy;
    repeat (2) cyc();
    rst = 1'b0;
    seed(32'h0);
  endtask

  // Monitor: pops the scoreboard on every consumed instruction and checks
  // request stability and occupancy consistency.
  initial begin
    logic        prev_pend;
    logic [31:0] prev_addr;
    exp_t        e;
    prev_pend = 1'b0;
    prev_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_pend) begin
          chk("req_held", 32'(bus.imem_req), 32'h1);
          chk("addr_stable", bus.imem_addr, prev_addr);
        end
        chk("count_bound", 32'(bus.queue_count <= 3'(DEPTH)), 32'h1);
        chk("valid_vs_count", 32'(bus.instr_valid), 32'(bus.queue_count != 3'd0));
        if (bus.instr_valid && bus.instr_ready && !bus.redirect) begin
          n_pops++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_empty actual_pc=%h", bus.instr_pc);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pc", bus.instr_pc, e.pc);
            chk("sb_instr", bus.instr, e.ins);
          end
        end
        prev_pend = bus.imem_req && !bus.imem_ack;
        prev_addr = bus.imem_addr;
      end else begin
        prev_pend = 1'b0;
      end
    end
  end

  initial begin
    int pops0;
    logic [31:0] rpc;
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    #3;
    chk("rst_req", 32'(bus.imem_req), 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc", bus.instr_pc, 32'h0);
    chk("rst_count", 32'(bus.queue_count), 32'h0);

    // Zero-wait streaming.
    do_reset(1'b1);
    #1;
    chk("t1_req0", 32'(bus.imem_req), 32'h1);
    chk("t1_addr0", bus.imem_addr, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      cyc(); #1;
      chk("t1_addr", bus.imem_addr, 32'(4 * k));
      chk("t1_valid", 32'(bus.instr_valid), 32'h1);
      chk("t1_pc", bus.instr_pc, 32'(4 * (k - 1)));
      chk("t1_count", 32'(bus.queue_count), 32'h1);
    end

    // Back-pressure fills the queue, then drains in order.
    do_reset(1'b0);
    #1;
    chk("t2_count", 32'(bus.queue_count), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      cyc(); #1;
      chk("t2_count", 32'(bus.queue_count), 32'(k));
    end
    chk("t2_full_noreq", 32'(bus.imem_req), 32'h0);
    cyc(); bus.instr_ready = 1'b1; #1;
    chk("t2_noreq", 32'(bus.imem_req), 32'h0);
    chk("t2_head0", bus.instr_pc, 32'h0);
    cyc(); #1;
    chk("t2_count3", 32'(bus.queue_count), 32'h3);
    chk("t2_req", 32'(bus.imem_req), 32'h1);
    chk("t2_addr16", bus.imem_addr, 32'h10);
    chk("t2_head4", bus.instr_pc, 32'h4);
    cyc(); #1;
    chk("t2_head8", bus.instr_pc, 32'h8);
    chk("t2_count_pp", 32'(bus.queue_count), 32'h3);

    // Three-cycle memory latency at address 8.
    do_reset(1'b1);
    cyc(); cyc(); mem_lat = 2; #1;
    chk("t3_addr_c1", bus.imem_addr, 32'h8);
    chk("t3_noack", 32'(bus.imem_ack), 32'h0);
    cyc(); #1;
    chk("t3_addr_c2", bus.imem_addr, 32'h8);
    chk("t3_req_c2", 32'(bus.imem_req), 32'h1);
    cyc(); #1;
    chk("t3_addr_c3", bus.imem_addr, 32'h8);
    chk("t3_ack", 32'(bus.imem_ack), 32'h1);
    cyc(); mem_lat = 0; #1;
    chk("t3_valid", 32'(bus.instr_valid), 32'h1);
    chk("t3_instr", bus.instr, 32'hE3A01005);
    chk("t3_pc", bus.instr_pc, 32'h8);

    // Redirect while waiting at 0x10: drain, then resume at 0x100.
    do_reset(1'b0);
    repeat (4) cyc();
    bus.instr_ready = 1'b1;
    cyc(); bus.instr_ready = 1'b0; mem_lat = 10; #1;
    chk("t4_addr", bus.imem_addr, 32'h10);
    chk("t4_count", 32'(bus.queue_count), 32'h3);
    cyc(); bus.redirect = 1'b1; bus.redirect_pc = 32'h103; seed(32'h100); #1;
    chk("t4_addr_hold", bus.imem_addr, 32'h10);
    cyc(); bus.redirect = 1'b0; mem_lat = 3; #1;
    chk("t4_flush_cnt", 32'(bus.queue_count), 32'h0);
    chk("t4_flush_vld", 32'(bus.instr_valid), 32'h0);
    chk("t4_drain_req", 32'(bus.imem_req), 32'h1);
    chk("t4_drain_addr", bus.imem_addr, 32'h10);
    cyc(); bus.instr_ready = 1'b1; #1;
    chk("t4_drain_ack", 32'(bus.imem_ack), 32'h1);
    chk("t4_drain_addr2", bus.imem_addr, 32'h10);
    cyc(); mem_lat = 0; #1;
    chk("t4_new_req", 32'(bus.imem_req), 32'h1);
    chk("t4_new_addr", bus.imem_addr, 32'h100);
    cyc(); #1;
    chk("t4_valid", 32'(bus.instr_valid), 32'h1);
    chk("t4_pc", bus.instr_pc, 32'h100);
    chk("t4_instr", bus.instr, memf(32'h100));

    // Redirect coincident with the ack for 0x20.
    do_reset(1'b1);
    repeat (8) cyc();
    mem_lat = 1; #1;
    chk("t5_addr", bus.imem_addr, 32'h20);
    chk("t5_noack", 32'(bus.imem_ack), 32'h0);
    cyc(); bus.redirect = 1'b1; bus.redirect_pc = 32'h200; seed(32'h200); #1;
    chk("t5_ack", 32'(bus.imem_ack), 32'h1);
    cyc(); bus.redirect = 1'b0; mem_lat = 0; #1;
    chk("t5_count", 32'(bus.queue_count), 32'h0);
    chk("t5_valid", 32'(bus.instr_valid), 32'h0);
    chk("t5_addr_new", bus.imem_addr, 32'h200);
    cyc(); #1;
    chk("t5_pc", bus.instr_pc, 32'h200);

    // Reset pulse in the middle of a wait with two queued entries.
    do_reset(1'b0);
    cyc(); cyc(); mem_lat = 10; #1;
    chk("t6_addr", bus.imem_addr, 32'h8);
    chk("t6_count", 32'(bus.queue_count), 32'h2);
    cyc(); rst = 1'b1; #1;
    chk("t6_rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("t6_rst_count", 32'(bus.queue_count), 32'h0);
    chk("t6_rst_req", 32'(bus.imem_req), 32'h0);
    cyc(); rst = 1'b0; mem_lat = 0; seed(32'h0); #1;
    chk("t6_req", 32'(bus.imem_req), 32'h1);
    chk("t6_addr0", bus.imem_addr, 32'h0);

    // Randomized traffic with random latency, back-pressure and redirects.
    do_reset(1'b1);
    pops0 = n_pops;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      mem_lat = $urandom_range(0, 3);
      if ($urandom_range(0, 24) == 0) begin
        if ($urandom_range(0, 3) == 0) rpc = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
        else rpc = $urandom & 32'h0000FFFF;
        bus.redirect    = 1'b1;
        bus.redirect_pc = rpc;
        seed(rpc & 32'hFFFFFFFC);
      end else begin
        bus.redirect = 1'b0;
      end
    end
    cyc();
    bus.redirect = 1'b0;
    chk("rand_progress", 32'((n_pops - pops0) > 100), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the single-cycle ARM core datapath.
- Holds the fetch PC and issues word requests to instruction memory over a req/ack handshake.
- Buffers returned instructions in a small prefetch queue and presents them to the core with a valid/ready handshake.
- Supports branch redirect with queue flush and discard of any in-flight response.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address.
- DATA_W, 32, instruction width.
- RESET_PC, 0, first fetch address after reset; must be 4-aligned.
- DEPTH, 4, prefetch queue entries; legal values are 2, 4 or 8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous assert, active-high.
- imem_req  out  1  request valid; held until ack.
- imem_addr  out  ADDR_W  request address; stable while imem_req=1.
- imem_ack  in  1  response strobe; imem_rdata is valid in this cycle.
- imem_rdata  in  DATA_W  returned instruction.
- instr_valid  out  1  queue head is valid.
- instr  out  DATA_W  queue head instruction.
- instr_pc  out  ADDR_W  address of queue head.
- instr_ready  in  1  core consumes head when valid&ready.
- redirect  in  1  branch taken; single-cycle pulse.
- redirect_pc  in  ADDR_W  new fetch address; bits[1:0] are ignored and forced to 0.
- queue_count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (asynchronous, rst=1): fetch_pc=RESET_PC, state=IDLE, queue empty, and all outputs 0: imem_req, imem_addr, instr_valid, instr, instr_pc, queue_count.
- State machine has three states: IDLE, WAIT, DRAIN.
- IDLE:
  - If count<DEPTH and redirect=0, drive imem_req=1 and imem_addr=fetch_pc combinationally, and evaluate ack in the same cycle.
  - ack=1 → push {rdata, fetch_pc}, fetch_pc+=4, stay in IDLE.
  - ack=0 → go to WAIT.
- WAIT:
  - imem_req=1, imem_addr=fetch_pc, held stable.
  - On ack → push, fetch_pc+=4, go to IDLE.
- DRAIN:
  - imem_req=1 with the stale address held.
  - On ack → discard rdata, go to IDLE.
  - fetch_pc already holds the redirect target.
- Request gating: a request is issued only when count<DEPTH at issue time.
  - Only one request is outstanding at any time.
  - A push into a full queue is therefore impossible; a same-cycle pop frees space for the next issue, not the current one.
- Queue:
  - Circular buffer with read/write pointers that wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - instr_valid = (count!=0); instr and instr_pc come from the head entry, registered storage with a combinational read.
- Throughput: 1 instruction/cycle with zero-wait-state memory (ack in the request cycle). The first instr_valid appears 1 cycle after the first ack.
- Redirect (takes priority over everything in that cycle):
  - Flush queue (count=0, pointers reset) and set fetch_pc=redirect_pc&~3.
  - Any same-cycle pop is ignored.
  - In IDLE, no request is issued in the redirect cycle; fetching resumes the next cycle.
  - In WAIT with ack=0 → DRAIN. In WAIT with ack=1 → discard rdata, go to IDLE.
  - In DRAIN → stay in DRAIN, update fetch_pc to the newest redirect_pc.
- Overflow of fetch_pc wraps at 2^ADDR_W with no flag.
- rst asserted mid-transaction abandons the request immediately. A late ack after reset is ignored while state=IDLE only if imem_req=0 in that cycle; the memory is required to drop pending acks on rst.

Test Plan:
- Reset then zero-wait memory (ack=req), instr_ready=1 → imem_addr 0,4,8,…; instr_pc=0 with instr_valid=1 in cycle 2 after reset release; one new instruction every cycle.
- instr_ready=0, zero-wait memory → queue_count 1,2,3,4 then imem_req=0; raise ready → instructions at pc 0,4,8,12 in order, fetching resumes at 16.
- 3-cycle memory latency: imem_addr stays 0x8 for all 3 req cycles; rdata=0xE3A01005 → instr=0xE3A01005, instr_pc=0x8.
- Redirect to 0x103 while WAIT at addr 0x10 → queue empties next cycle, DRAIN holds req at 0x10; its ack data is dropped; next request is at 0x100, first valid instr_pc=0x100.
- Redirect in the same cycle as ack for 0x20 → that data is discarded, the queue is not written, next imem_addr=redirect target.
- Fill 2 entries, pulse rst for one cycle mid-WAIT → instr_valid=0, queue_count=0, imem_req=0 asynchronously; after release, first imem_addr=RESET_PC.
